m_dm_responder: RTL and testbench
=================================

Name: m_dm_responder

Overview:
- Data-memory responder at the M-stage end of the pipeline. It consumes the M-stage access fields: address from ALU result, store data, DMop, write enable.
- Performs word/half/byte loads and stores against an internal RAM with configurable multi-cycle latency.
- Its busy output is the stall source that drops the E/M and earlier register enables until the access completes.

Parameters:
DEPTH_WORDS, 3072, number of 32-bit words; valid byte addresses are 0 .. 4*DEPTH_WORDS-1
LATENCY, 2, WAIT cycles per access (0 allowed)

Ports:
clk  input  1  clock
reset  input  1  synchronous active-high reset
M_DM_req  input  1  access valid this cycle (load or store in M)
M_DM_write  input  1  1 = store, 0 = load
M_DMop  input  2  00 word, 01 half, 10 byte, 11 reserved (treated as error)
M_DM_sext  input  1  load extension: 1 sign, 0 zero (ignored for word)
M_ALUout  input  32  byte address
M_RD2  input  32  store data (low bits used for half/byte)
M_DM_busy  output  1  stall request to hazard/enable logic (combinational)
M_DM_done  output  1  one-cycle completion pulse (registered)
M_DM_err  output  1  access fault flag, valid while done=1 (registered)
M_DM_rdata  output  32  extended load data, valid while done=1 (registered)

Behaviour:
- Reset (sync, active-high):
  - State = IDLE; done=0, err=0, rdata=0, internal counter=0.
  - All RAM words cleared to 0.
  - Reset wins over any in-flight access; no write commits on a reset edge.
- States: IDLE, WAIT, DONE.
- M_DM_busy = M_DM_req & (state != DONE). It is 0 whenever req=0.
- IDLE:
  - req=0: stay in IDLE.
  - req=1: latch addr, wdata, op, write, sext.
  - Fault check on the latched request: fault if word with addr[1:0]!=0, half with addr[0]!=0, op=11, or addr >= 4*DEPTH_WORDS.
  - Fault: go to DONE with err=1; no RAM write; rdata=0.
  - No fault, LATENCY=0: go to DONE and perform the access on this edge.
  - No fault, LATENCY>0: go to WAIT with counter=LATENCY-1.
- WAIT:
  - req=0 (flush/abort): go to IDLE; no write; done stays 0.
  - counter!=0: decrement.
  - counter==0: go to DONE and perform the access on this edge.
- Access on entering DONE:
  - Store: write only the byte lanes selected by op and address. Byte uses lane addr[1:0], data wdata[7:0] to bits 8*lane+7..8*lane. Half uses lane addr[1], data wdata[15:0]. Word uses all lanes.
  - Load: extract the same lane and sign- or zero-extend to 32 bits into rdata. Store sets rdata=0.
- DONE:
  - done=1 for exactly one cycle; busy=0 so the pipeline advances on this edge.
  - Unconditionally go to IDLE next; done and err return to 0.
- Back-to-back: a new req seen in IDLE the cycle after DONE starts a fresh access. Minimum access period is LATENCY+2 cycles (IDLE, WAIT×LATENCY, DONE).
- Input stability: inputs are sampled only in IDLE. Changes during WAIT other than req have no effect.
- Byte order is little-endian within a word.
- Address bits above the word index are ignored once in range.

Test Plan:
- LATENCY=2, store word 0x12345678 to 0x10: busy high for 3 cycles (IDLE, WAIT, WAIT), done pulses on the 4th cycle. Then load word 0x10 gives done with rdata=0x12345678, err=0.
- Store byte 0x80 to 0x21, then load byte 0x21 with sext=1: rdata=0xFFFFFF80. With sext=0: rdata=0x00000080. Load word 0x20: rdata=0x00008000.
- Store half 0xBEEF to 0x22, then load half 0x22 with sext=1: rdata=0xFFFFBEEF. Store half to 0x23: done with err=1, and word 0x20 is unchanged.
- Address 0x3000 (DEPTH 3072) or op=11: err=1 after one cycle (IDLE to DONE directly), no RAM change, rdata=0.
- Store word to 0x40, drop req in the first WAIT cycle: state returns to IDLE, no done, and a later load of 0x40 reads 0. Repeat the store with reset asserted mid-WAIT: all outputs return to 0 and the word is 0.
- LATENCY=0: two back-to-back word stores to 0x0 and 0x4. Each has busy for 1 cycle and done the next cycle. Loads then return both values.

Source files
------------

// File: rtl/m_dm_responder_if.sv
// Purpose: M-stage data-memory access bundle between the pipeline and the
//          data-memory responder.
// Signals:
//   M_DM_req    access valid this cycle (load or store in M)
//   M_DM_write  1 = store, 0 = load
//   M_DMop      00 word, 01 half, 10 byte, 11 reserved
//   M_DM_sext   load extension: 1 sign, 0 zero
//   M_ALUout    byte address
//   M_RD2       store data
//   M_DM_busy   stall request (combinational)
//   M_DM_done   one-cycle completion pulse
//   M_DM_err    access fault flag, valid with done
//   M_DM_rdata  extended load data, valid with done
// Modports: master = pipeline side, slave = responder side.
interface m_dm_responder_if;
    logic        M_DM_req;
    logic        M_DM_write;
    logic [1:0]  M_DMop;
    logic        M_DM_sext;
    logic [31:0] M_ALUout;
    logic [31:0] M_RD2;
    logic        M_DM_busy;
    logic        M_DM_done;
    logic        M_DM_err;
    logic [31:0] M_DM_rdata;

    modport master (
        output M_DM_req, M_DM_write, M_DMop, M_DM_sext, M_ALUout, M_RD2,
        input  M_DM_busy, M_DM_done, M_DM_err, M_DM_rdata
    );

    modport slave (
        input  M_DM_req, M_DM_write, M_DMop, M_DM_sext, M_ALUout, M_RD2,
        output M_DM_busy, M_DM_done, M_DM_err, M_DM_rdata
    );
endinterface

// File: rtl/m_dm_responder.sv
// Purpose: M-stage data-memory responder. Serves word/half/byte loads and
//          stores against an internal little-endian RAM with LATENCY wait
//          cycles per access, and raises busy as the pipeline stall source.
// Ports:
//   clk    clock
//   reset  synchronous active-high reset (clears state, outputs and RAM)
//   dm     access bundle (slave side): request fields in, busy/done/err/rdata out
// Parameters:
//   DEPTH_WORDS  number of 32-bit words; byte addresses 0 .. 4*DEPTH_WORDS-1
//   LATENCY      WAIT cycles per access (0 allowed)
module m_dm_responder #(
    parameter int unsigned DEPTH_WORDS = 3072,
    parameter int unsigned LATENCY     = 2
) (
    input  logic              clk,
    input  logic              reset,
    m_dm_responder_if.slave   dm
);

    localparam int unsigned IDX_W      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int unsigned CNT_W      = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [32:0] ADDR_LIMIT = 33'(4 * DEPTH_WORDS);

    localparam logic [1:0] OP_WORD = 2'b00;
    localparam logic [1:0] OP_HALF = 2'b01;
    localparam logic [1:0] OP_BYTE = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [31:0]        addr_q, wdata_q;
    logic [1:0]         op_q;
    logic               write_q, sext_q;

    logic               done_q, done_d;
    logic               err_q, err_d;
    logic [31:0]        rdata_q, rdata_d;

    logic [31:0]        mem_q [DEPTH_WORDS];

    logic [31:0]        acc_addr_c, acc_wdata_c;
    logic [1:0]         acc_op_c;
    logic               acc_write_c, acc_sext_c;
    logic               fault_c;
    logic [IDX_W-1:0]   idx_c;
    logic [31:0]        rd_word_c;
    logic [31:0]        load_data_c;
    logic [31:0]        st_data_c;
    logic [3:0]         st_be_c;
    logic               mem_we_c;
    logic               latch_en_c;

    // Access fields: live inputs while in IDLE (needed when LATENCY=0 or on
    // a fault), otherwise the copy latched on leaving IDLE.
    always_comb begin : acc_select
        if (state_q == S_IDLE) begin
            acc_addr_c  = dm.M_ALUout;
            acc_wdata_c = dm.M_RD2;
            acc_op_c    = dm.M_DMop;
            acc_write_c = dm.M_DM_write;
            acc_sext_c  = dm.M_DM_sext;
        end else begin
            acc_addr_c  = addr_q;
            acc_wdata_c = wdata_q;
            acc_op_c    = op_q;
            acc_write_c = write_q;
            acc_sext_c  = sext_q;
        end
    end

    // Misalignment, reserved op or out-of-range address.
    always_comb begin : fault_check
        fault_c = 1'b0;
        if ({1'b0, acc_addr_c} >= ADDR_LIMIT)                        fault_c = 1'b1;
        if (acc_op_c == 2'b11)                                        fault_c = 1'b1;
        if ((acc_op_c == OP_WORD) && (acc_addr_c[1:0] != 2'b00))      fault_c = 1'b1;
        if ((acc_op_c == OP_HALF) && acc_addr_c[0])                   fault_c = 1'b1;
    end

    assign idx_c     = acc_addr_c[IDX_W+1:2];
    assign rd_word_c = mem_q[idx_c];

    // Load lane extraction and extension.
    always_comb begin : load_extract
        logic [15:0] half_v;
        logic [7:0]  byte_v;
        load_data_c = '0;
        half_v      = acc_addr_c[1] ? rd_word_c[31:16] : rd_word_c[15:0];
        byte_v      = rd_word_c[8*acc_addr_c[1:0] +: 8];
        case (acc_op_c)
            OP_WORD: load_data_c = rd_word_c;
            OP_HALF: load_data_c = {{16{acc_sext_c & half_v[15]}}, half_v};
            OP_BYTE: load_data_c = {{24{acc_sext_c & byte_v[7]}}, byte_v};
            default: load_data_c = '0;
        endcase
    end

    // Store lane replication and byte enables.
    always_comb begin : store_lanes
        st_data_c = acc_wdata_c;
        st_be_c   = 4'b0000;
        case (acc_op_c)
            OP_WORD: st_be_c = 4'b1111;
            OP_HALF: begin
                st_data_c = {2{acc_wdata_c[15:0]}};
                st_be_c   = acc_addr_c[1] ? 4'b1100 : 4'b0011;
            end
            OP_BYTE: begin
                st_data_c = {4{acc_wdata_c[7:0]}};
                st_be_c   = 4'(4'b0001 << acc_addr_c[1:0]);
            end
            default: st_be_c = 4'b0000;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin : state_reg
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // FSM next-state logic.
    always_comb begin : next_state
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (dm.M_DM_req) begin
                    if (fault_c || (LATENCY == 0)) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = CNT_W'(LATENCY - 1);
                    end
                end
            end
            S_WAIT: begin
                if (!dm.M_DM_req) begin
                    state_d = S_IDLE;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs: completion, fault, load data and RAM write strobe.
    always_comb begin : output_logic
        done_d     = 1'b0;
        err_d      = 1'b0;
        rdata_d    = '0;
        mem_we_c   = 1'b0;
        latch_en_c = (state_q == S_IDLE) && dm.M_DM_req;
        if (state_d == S_DONE) begin
            done_d = 1'b1;
            if (fault_c) begin
                err_d = 1'b1;
            end else if (acc_write_c) begin
                mem_we_c = 1'b1;
            end else begin
                rdata_d = load_data_c;
            end
        end
    end

    // Request latch and registered outputs.
    always_ff @(posedge clk) begin : out_regs
        if (reset) begin
            addr_q  <= '0;
            wdata_q <= '0;
            op_q    <= '0;
            write_q <= 1'b0;
            sext_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            if (latch_en_c) begin
                addr_q  <= dm.M_ALUout;
                wdata_q <= dm.M_RD2;
                op_q    <= dm.M_DMop;
                write_q <= dm.M_DM_write;
                sext_q  <= dm.M_DM_sext;
            end
            done_q  <= done_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    // RAM: cleared on reset, byte-lane writes on store commit.
    always_ff @(posedge clk) begin : ram
        if (reset) begin
            for (int i = 0; i < int'(DEPTH_WORDS); i++) begin
                mem_q[i] <= '0;
            end
        end else if (mem_we_c) begin
            for (int b = 0; b < 4; b++) begin
                if (st_be_c[b]) begin
                    mem_q[idx_c][8*b +: 8] <= st_data_c[8*b +: 8];
                end
            end
        end
    end

    assign dm.M_DM_busy  = dm.M_DM_req && (state_q != S_DONE);
    assign dm.M_DM_done  = done_q;
    assign dm.M_DM_err   = err_q;
    assign dm.M_DM_rdata = rdata_q;

endmodule

// File: tb/tb_m_dm_responder.sv
// Directed bench for m_dm_responder: one instance with LATENCY=2 and one
// with LATENCY=0, sharing the clock.
module tb_m_dm_responder;

    logic clk;
    logic rst2, rst0;
    int   n_tests;
    int   n_fail;

    m_dm_responder_if if2 ();
    m_dm_responder_if if0 ();

    m_dm_responder #(.DEPTH_WORDS(3072), .LATENCY(2)) u_dut2 (
        .clk   (clk),
        .reset (rst2),
        .dm    (if2.slave)
    );

    m_dm_responder #(.DEPTH_WORDS(3072), .LATENCY(0)) u_dut0 (
        .clk   (clk),
        .reset (rst0),
        .dm    (if0.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit sel, input logic req, input logic wr, input logic [1:0] op,
                         input logic sx, input logic [31:0] addr, input logic [31:0] wd);
        if (sel) begin
            if0.M_DM_req = req; if0.M_DM_write = wr; if0.M_DMop = op;
            if0.M_DM_sext = sx; if0.M_ALUout = addr; if0.M_RD2 = wd;
        end else begin
            if2.M_DM_req = req; if2.M_DM_write = wr; if2.M_DMop = op;
            if2.M_DM_sext = sx; if2.M_ALUout = addr; if2.M_RD2 = wd;
        end
    endtask

    function automatic logic get_busy(input bit sel);
        return sel ? if0.M_DM_busy : if2.M_DM_busy;
    endfunction

    function automatic logic get_done(input bit sel);
        return sel ? if0.M_DM_done : if2.M_DM_done;
    endfunction

    // One access: returns err/rdata at the done cycle, cycles from request
    // to done, and busy cycles seen before done. Ends one cycle after done.
    task automatic access(input bit sel, input logic wr, input logic [1:0] op, input logic sx,
                          input logic [31:0] addr, input logic [31:0] wd, input bit hold,
                          output logic err, output logic [31:0] rd, output int cyc,
                          output int bsy, output logic busy_at_done);
        drive(sel, 1'b1, wr, op, sx, addr, wd);
        #1;
        cyc = 0;
        bsy = 0;
        while (!get_done(sel) && cyc < 20) begin
            if (get_busy(sel)) bsy++;
            @(posedge clk); #1;
            cyc++;
        end
        busy_at_done = get_busy(sel);
        err = sel ? if0.M_DM_err : if2.M_DM_err;
        rd  = sel ? if0.M_DM_rdata : if2.M_DM_rdata;
        if (!hold) drive(sel, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
        @(posedge clk); #1;
    endtask

    initial begin : stim
        logic        err, bad;
        logic [31:0] rd;
        int          cyc, bsy;
        int          done_seen;

        n_tests = 0;
        n_fail  = 0;
        rst2 = 1'b1;
        rst0 = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_done",  32'(if2.M_DM_done), 32'h0);
        chk("rst_err",   32'(if2.M_DM_err), 32'h0);
        chk("rst_rdata", if2.M_DM_rdata, 32'h0);
        chk("rst_busy",  32'(if2.M_DM_busy), 32'h0);
        rst2 = 1'b0;
        rst0 = 1'b0;
        @(posedge clk); #1;

        // Word store / load with LATENCY=2.
        access(1'b0, 1'b1, 2'b00, 1'b0, 32'h10, 32'h12345678, 1'b0, err, rd, cyc, bsy, bad);
        chk("sw_cycles", 32'(cyc), 32'd3);
        chk("sw_busy",   32'(bsy), 32'd3);
        chk("sw_busy_done", 32'(bad), 32'h0);
        chk("sw_err",    32'(err), 32'h0);
        chk("sw_rdata",  rd, 32'h0);
        chk("sw_done_clr", 32'(if2.M_DM_done), 32'h0);
        access(1'b0, 1'b0, 2'b00, 1'b1, 32'h10, 32'h0, 1'b0, err, rd, cyc, bsy, bad);
        chk("lw_cycles", 32'(cyc), 32'd3);
        chk("lw_err",    32'(err), 32'h0);
        chk("lw_rdata",  rd, 32'h12345678);

        // Byte store / loads.
        access(1'b0, 1'b1, 2'b10, 1'b0, 32'h21, 32'hFFFFFF80, 1'b0, err, rd, cyc, bsy, bad);
        chk("sb_err", 32'(err), 32'h0);
        access(1'b0, 1'b0, 2'b10, 1'b1, 32'h21, 32'h0, 1'b0, err, rd, cyc, bsy, bad);
        chk("lb_sext", rd, 32'hFFFFFF80);
        access(1'b0, 1'b0, 2'b10, 1'b0, 32'h21, 32'h0, 1'b0, err, rd, cyc, bsy, bad);
        chk("lbu", rd, 32'h00000080);
        access(1'b0, 1'b0, 2'b00, 1'b0, 32'h20, 32'h0, 1'b0, err, rd, cyc, bsy, bad);
        chk("lw_after_sb", rd, 32'h00008000);

        // Half store / loads, misaligned half.
        access(1'b0, 1'b1, 2'b01, 1'b0, 32'h22, 32'h1234BEEF, 1'b0, err, rd, cyc, bsy, bad);
        chk("sh_err", 32'(err), 32'h0);
        access(1'b0, 1'b0, 2'b01, 1'b1, 32'h22, 32'h0, 1'b0, err, rd, cyc, bsy, bad);
        chk("lh_sext", rd, 32'hFFFFBEEF);
        access(1'b0, 1'b0, 2'b01, 1'b0, 32'h22, 32'h0, 1'b0, err, rd, cyc, bsy, bad);
        chk("lhu", rd, 32'h0000BEEF);
        access(1'b0, 1'b1, 2'b01, 1'b0, 32'h23, 32'h00001111, 1'b0, err, rd, cyc, bsy, bad);
        chk("sh_mis_err", 32'(err), 32'h1);
        chk("sh_mis_cycles", 32'(cyc), 32'd1);
        access(1'b0, 1'b0, 2'b00, 1'b0, 32'h20, 32'h0, 1'b0, err, rd, cyc, bsy, bad);
        chk("lw_after_mis", rd, 32'hBEEF8000);

        // Misaligned word load, out-of-range and reserved op.
        access(1'b0, 1'b0, 2'b00, 1'b0, 32'h12, 32'h0, 1'b0, err, rd, cyc, bsy, bad);
        chk("lw_mis_err", 32'(err), 32'h1);
        access(1'b0, 1'b1, 2'b00, 1'b0, 32'h3000, 32'hCAFEF00D, 1'b0, err, rd, cyc, bsy, bad);
        chk("oor_err",    32'(err), 32'h1);
        chk("oor_cycles", 32'(cyc), 32'd1);
        chk("oor_rdata",  rd, 32'h0);
        access(1'b0, 1'b0, 2'b00, 1'b0, 32'h2FFC, 32'h0, 1'b0, err, rd, cyc, bsy, bad);
        chk("last_word_err", 32'(err), 32'h0);
        access(1'b0, 1'b0, 2'b11, 1'b0, 32'h10, 32'h0, 1'b0, err, rd, cyc, bsy, bad);
        chk("op11_err",    32'(err), 32'h1);
        chk("op11_cycles", 32'(cyc), 32'd1);
        chk("op11_rdata",  rd, 32'h0);
        access(1'b0, 1'b0, 2'b00, 1'b0, 32'h10, 32'h0, 1'b0, err, rd, cyc, bsy, bad);
        chk("lw_after_faults", rd, 32'h12345678);

        // Abort: drop req during the first WAIT cycle.
        drive(1'b0, 1'b1, 1'b1, 2'b00, 1'b0, 32'h40, 32'hDEADBEEF);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 32'h40, 32'hDEADBEEF);
        #1;
        chk("abort_busy", 32'(if2.M_DM_busy), 32'h0);
        done_seen = 0;
        repeat (4) begin
            @(posedge clk); #1;
            if (if2.M_DM_done) done_seen++;
        end
        chk("abort_no_done", 32'(done_seen), 32'd0);
        access(1'b0, 1'b0, 2'b00, 1'b0, 32'h40, 32'h0, 1'b0, err, rd, cyc, bsy, bad);
        chk("abort_mem", rd, 32'h0);

        // Reset on the would-be commit edge; RAM is cleared as well.
        access(1'b0, 1'b1, 2'b00, 1'b0, 32'h44, 32'h55AA55AA, 1'b0, err, rd, cyc, bsy, bad);
        access(1'b0, 1'b0, 2'b00, 1'b0, 32'h44, 32'h0, 1'b0, err, rd, cyc, bsy, bad);
        chk("pre_rst_word", rd, 32'h55AA55AA);
        drive(1'b0, 1'b1, 1'b1, 2'b00, 1'b0, 32'h40, 32'h11112222);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst2 = 1'b1;
        @(posedge clk); #1;
        rst2 = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
        #1;
        chk("mid_rst_done",  32'(if2.M_DM_done), 32'h0);
        chk("mid_rst_err",   32'(if2.M_DM_err), 32'h0);
        chk("mid_rst_rdata", if2.M_DM_rdata, 32'h0);
        chk("mid_rst_busy",  32'(if2.M_DM_busy), 32'h0);
        access(1'b0, 1'b0, 2'b00, 1'b0, 32'h40, 32'h0, 1'b0, err, rd, cyc, bsy, bad);
        chk("mid_rst_mem40", rd, 32'h0);
        access(1'b0, 1'b0, 2'b00, 1'b0, 32'h44, 32'h0, 1'b0, err, rd, cyc, bsy, bad);
        chk("mid_rst_mem44", rd, 32'h0);

        // LATENCY=0: back-to-back stores, then loads.
        access(1'b1, 1'b1, 2'b00, 1'b0, 32'h0, 32'hA5A50001, 1'b1, err, rd, cyc, bsy, bad);
        chk("l0_s0_cycles", 32'(cyc), 32'd1);
        chk("l0_s0_busy",   32'(bsy), 32'd1);
        chk("l0_s0_busy_done", 32'(bad), 32'h0);
        access(1'b1, 1'b1, 2'b00, 1'b0, 32'h4, 32'h0BADF00D, 1'b1, err, rd, cyc, bsy, bad);
        chk("l0_s1_cycles", 32'(cyc), 32'd1);
        chk("l0_s1_busy",   32'(bsy), 32'd1);
        access(1'b1, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 1'b1, err, rd, cyc, bsy, bad);
        chk("l0_l0_rdata", rd, 32'hA5A50001);
        access(1'b1, 1'b0, 2'b00, 1'b0, 32'h4, 32'h0, 1'b0, err, rd, cyc, bsy, bad);
        chk("l0_l1_rdata", rd, 32'h0BADF00D);
        chk("l0_l1_cycles", 32'(cyc), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
